traveler_target_decoder: RTL and testbench

//  Receiving end of the target-machine select channel. Watches the 8-bit frame
//  bus {0, select[4:0], channel[1:0]} and debounces each new frame value.

---
 rtl/traveler_target_decoder.sv | 185 ++++++++++++++++++
 tb/tb_traveler_target_decoder.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traveler_target_decoder.sv
// -----------------------------------------------------------------------------
// traveler_target_decoder
//
// Receiving end of the target-machine select channel. The 8-bit frame bus
// carries {b7=0, id[4:0], channel[1:0]}. Each new frame value is debounced.
// Settled frames on our channel are classified as one of: ignore (clears the
// target), illegal (error pulse), duplicate (no event) or a new target. A new
// target id is offered to the game logic over a valid/ready handshake.
//
// Ports
//   clk            system clock
//   rst            synchronous reset, active-high
//   data_in  [7:0] frame bus {b7, id[4:0], channel[1:0]}
//   tgt_ready      consumer accepts tgt_id this cycle
//   tgt_valid      tgt_id holds a new target that has not been accepted yet
//   tgt_id   [4:0] target id offered with tgt_valid
//   cur_target[4:0] last decoded legal id (0 when inactive)
//   target_active  cur_target is meaningful
//   err_frame      one-cycle pulse: frame on our channel but illegal
//   frame_cnt[7:0] accepted handshakes, saturating at 255
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | waiting for a settled frame or for a frame parked in pending
// DECODE | classifying dec_frame; updates the target registers
// HOLD   | tgt_valid high, waiting for tgt_ready
// -----------------------------------------------------------------------------
module traveler_target_decoder #(
   parameter int unsigned STABLE_CNT       = 4,
   parameter int unsigned SELECT_VALUE_MAX = 20,
   parameter logic [1:0]  CHANNEL_TARGET   = 2'b11,
   parameter logic [7:0]  SELECT_IGNORE    = 8'h03
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data_in,
   input  logic       tgt_ready,
   output logic       tgt_valid,
   output logic [4:0] tgt_id,
   output logic [4:0] cur_target,
   output logic       target_active,
   output logic       err_frame,
   output logic [7:0] frame_cnt
);

   localparam int unsigned CW = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
   localparam logic [CW-1:0] STAB_LAST = CW'(STABLE_CNT - 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DECODE = 2'd1;
   localparam logic [1:0] ST_HOLD   = 2'd2;

   logic [1:0]    state;
   logic [7:0]    prev_data;
   logic [CW-1:0] stab_cnt;
   logic          settled;
   logic          settle;
   logic [7:0]    dec_frame;
   logic          pend_valid;
   logic [7:0]    pend_frame;

   // ---------------------------------------------------------------------------
   // Debounce. The settle pulse is combinational so the FSM can capture the
   // frame on the same edge that marks it settled; the settled flag keeps a
   // value from settling twice.
   // ---------------------------------------------------------------------------
   assign settle = (data_in == prev_data) && !settled && (stab_cnt == STAB_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_data <= 8'h00;
         stab_cnt  <= '0;
         settled   <= 1'b0;
      end else begin
         prev_data <= data_in;
         if (data_in != prev_data) begin
            stab_cnt <= '0;
            settled  <= 1'b0;
         end else if (!settled) begin
            if (stab_cnt == STAB_LAST) begin
               settled <= 1'b1;
            end else begin
               stab_cnt <= stab_cnt + CW'(1);
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Frame classification of the frame being decoded
   // ---------------------------------------------------------------------------
   logic [4:0] dec_id;
   logic       on_channel;
   logic       is_ignore;
   logic       is_illegal;
   logic       is_dup;

   always_comb begin
      dec_id     = dec_frame[6:2];
      on_channel = (dec_frame[1:0] == CHANNEL_TARGET);
      is_ignore  = (dec_frame == SELECT_IGNORE);
      is_illegal = dec_frame[7] || (32'(dec_id) > SELECT_VALUE_MAX);
      is_dup     = target_active && (dec_id == cur_target);
   end

   // ---------------------------------------------------------------------------
   // Control FSM, pending slot and output registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         dec_frame     <= 8'h00;
         pend_valid    <= 1'b0;
         pend_frame    <= 8'h00;
         tgt_valid     <= 1'b0;
         tgt_id        <= 5'd0;
         cur_target    <= 5'd0;
         target_active <= 1'b0;
         err_frame     <= 1'b0;
         frame_cnt     <= 8'd0;
      end else begin
         err_frame <= 1'b0;
         case (state)
            ST_IDLE: begin
               // A parked frame is older than anything settling now, so it
               // goes first and the fresh one takes its place in the slot.
               if (pend_valid) begin
                  dec_frame <= pend_frame;
                  state     <= ST_DECODE;
                  if (settle) begin
                     pend_frame <= prev_data;
                  end else begin
                     pend_valid <= 1'b0;
                  end
               end else if (settle) begin
                  dec_frame <= prev_data;
                  state     <= ST_DECODE;
               end
            end

            ST_DECODE: begin
               if (settle) begin
                  pend_valid <= 1'b1;
                  pend_frame <= prev_data;
               end
               state <= ST_IDLE;
               if (on_channel) begin
                  if (is_ignore) begin
                     cur_target    <= 5'd0;
                     target_active <= 1'b0;
                  end else if (is_illegal) begin
                     err_frame <= 1'b1;
                  end else if (!is_dup) begin
                     cur_target    <= dec_id;
                     target_active <= 1'b1;
                     tgt_id        <= dec_id;
                     tgt_valid     <= 1'b1;
                     state         <= ST_HOLD;
                  end
               end
            end

            ST_HOLD: begin
               // Newer settles overwrite the slot; only the latest survives.
               if (settle) begin
                  pend_valid <= 1'b1;
                  pend_frame <= prev_data;
               end
               if (tgt_valid && tgt_ready) begin
                  tgt_valid <= 1'b0;
                  state     <= ST_IDLE;
                  if (frame_cnt != 8'hFF) begin
                     frame_cnt <= frame_cnt + 8'd1;
                  end
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_traveler_target_decoder.sv
// -----------------------------------------------------------------------------
// tb_traveler_target_decoder
//
// Directed scenarios for debounce latency, glitch rejection, id range, channel
// filtering, pending-slot overwrite and counter saturation, plus a randomized
// frame stream checked against a frame-level reference model (run-length
// debounce, then classification with plain arithmetic).
// -----------------------------------------------------------------------------
module tb_traveler_target_decoder;

   localparam int STABLE_CNT = 4;
   localparam int ID_MAX     = 20;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] data_in;
   logic       tgt_ready;
   logic       tgt_valid;
   logic [4:0] tgt_id;
   logic [4:0] cur_target;
   logic       target_active;
   logic       err_frame;
   logic [7:0] frame_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   int got_q[$];
   int err_seen = 0;

   // reference model
   bit model_on = 0;
   int m_last, m_run, m_cur, m_act, m_cnt, m_err;
   int exp_q[$];

   traveler_target_decoder #(
      .STABLE_CNT       (STABLE_CNT),
      .SELECT_VALUE_MAX (ID_MAX),
      .CHANNEL_TARGET   (2'b11),
      .SELECT_IGNORE    (8'h03)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .data_in       (data_in),
      .tgt_ready     (tgt_ready),
      .tgt_valid     (tgt_valid),
      .tgt_id        (tgt_id),
      .cur_target    (cur_target),
      .target_active (target_active),
      .err_frame     (err_frame),
      .frame_cnt     (frame_cnt)
   );

   always #5 clk = ~clk;

   // handshakes about to complete and error pulses, sampled mid-cycle
   always @(negedge clk) begin
      if (!rst && tgt_valid && tgt_ready) got_q.push_back(int'(tgt_id));
      if (err_frame) err_seen++;
   end

   function automatic void model_settle(input int v);
      int ch, id;
      ch = v % 4;
      id = (v / 4) % 32;
      if (ch != 3) return;
      if (v == 3) begin
         m_cur = 0;
         m_act = 0;
      end else if (v >= 128 || id > ID_MAX) begin
         m_err++;
      end else if (!(m_act == 1 && id == m_cur)) begin
         m_cur = id;
         m_act = 1;
         exp_q.push_back(id);
         if (m_cnt < 255) m_cnt++;
      end
   endfunction

   // A value has settled once it has been sampled on STABLE_CNT+1 edges in a
   // row (reset counts as one virtual sample of 8'h00).
   task automatic tick();
      @(posedge clk);
      #1;
      if (model_on) begin
         if (int'(data_in) == m_last) m_run++;
         else begin
            m_last = int'(data_in);
            m_run  = 1;
         end
         if (m_run == STABLE_CNT + 1) model_settle(m_last);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_valid(input string tag, output bit ok);
      ok = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (tgt_valid === 1'b1) begin
            ok = 1;
            break;
         end
      end
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s_timeout tgt_valid never rose within 20 cycles", tag);
      end
   endtask

   task automatic test_reset();
      data_in   = 8'h00;
      tgt_ready = 1'b0;
      do_reset();
      n_checks++;
      if ({tgt_valid, tgt_id, cur_target, target_active, err_frame, frame_cnt} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs got v=%0b id=%0d cur=%0d act=%0b err=%0b cnt=%0d exp all 0",
                  tgt_valid, tgt_id, cur_target, target_active, err_frame, frame_cnt);
      end
      for (int k = 0; k < 8; k++) tick();
      n_checks++;
      if (tgt_valid !== 1'b0 || err_frame !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle_zero_frame got v=%0b err=%0b exp 0 0", tgt_valid, err_frame);
      end
   endtask

   task automatic test_latency();
      tgt_ready = 1'b1;
      data_in   = 8'h17;
      for (int k = 0; k <= 4; k++) begin
         tick();
         n_checks++;
         if (tgt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_early_valid at E%0d got=%0b exp=0", k, tgt_valid);
         end
      end
      tick();
      n_checks++;
      if (tgt_valid !== 1'b1 || tgt_id !== 5'd5 || cur_target !== 5'd5 || target_active !== 1'b1) begin
         n_fail++;
         $display("FAIL latency_E5 got v=%0b id=%0d cur=%0d act=%0b exp 1 5 5 1",
                  tgt_valid, tgt_id, cur_target, target_active);
      end
      tick();
      n_checks++;
      if (tgt_valid !== 1'b0 || frame_cnt !== 8'd1) begin
         n_fail++;
         $display("FAIL latency_E6 got v=%0b cnt=%0d exp 0 1", tgt_valid, frame_cnt);
      end
   endtask

   task automatic test_debounce();
      int vcount, base, eb;
      vcount = 0;
      base   = got_q.size();
      eb     = err_seen;
      tgt_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         data_in = (i % 2 == 0) ? 8'h1B : 8'h17;
         tick();
         if (tgt_valid === 1'b1) vcount++;
         tick();
         if (tgt_valid === 1'b1) vcount++;
      end
      n_checks++;
      if (vcount != 0) begin
         n_fail++;
         $display("FAIL debounce_glitch_events got=%0d exp=0", vcount);
      end
      data_in = 8'h1B;
      for (int k = 0; k < 20; k++) tick();
      n_checks++;
      if (got_q.size() - base != 1 || (got_q.size() > base && got_q[base] != 6)) begin
         n_fail++;
         $display("FAIL debounce_single_id6 got %0d handshakes (first=%0d) exp 1 with id 6",
                  got_q.size() - base, (got_q.size() > base) ? got_q[base] : -1);
      end
      n_checks++;
      if (err_seen != eb) begin
         n_fail++;
         $display("FAIL debounce_err got=%0d exp=0", err_seen - eb);
      end
   endtask

   task automatic test_range();
      bit ok;
      int vcount, eb;
      tgt_ready = 1'b1;
      data_in   = 8'h53;
      wait_valid("range_id20", ok);
      n_checks++;
      if (tgt_id !== 5'd20) begin
         n_fail++;
         $display("FAIL range_id20 got=%0d exp=20", tgt_id);
      end
      for (int k = 0; k < 4; k++) tick();
      eb = err_seen;
      vcount = 0;
      data_in = 8'h57;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (tgt_valid === 1'b1) vcount++;
      end
      n_checks++;
      if (err_seen - eb != 1) begin
         n_fail++;
         $display("FAIL range_err_pulse got=%0d pulses exp=1", err_seen - eb);
      end
      n_checks++;
      if (vcount != 0 || cur_target !== 5'd20 || target_active !== 1'b1) begin
         n_fail++;
         $display("FAIL range_target_kept got v=%0d cur=%0d act=%0b exp 0 20 1",
                  vcount, cur_target, target_active);
      end
   endtask

   task automatic test_channel();
      int vcount, eb;
      vcount = 0;
      eb = err_seen;
      tgt_ready = 1'b1;
      data_in = 8'h16;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (tgt_valid === 1'b1) vcount++;
      end
      n_checks++;
      if (vcount != 0 || err_seen != eb || cur_target !== 5'd20) begin
         n_fail++;
         $display("FAIL channel_other got v=%0d err=%0d cur=%0d exp 0 0 20",
                  vcount, err_seen - eb, cur_target);
      end
      data_in = 8'h03;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (tgt_valid === 1'b1) vcount++;
      end
      n_checks++;
      if (vcount != 0 || target_active !== 1'b0 || cur_target !== 5'd0) begin
         n_fail++;
         $display("FAIL channel_ignore got v=%0d act=%0b cur=%0d exp 0 0 0",
                  vcount, target_active, cur_target);
      end
   endtask

   task automatic test_pending();
      bit ok;
      int base;
      tgt_ready = 1'b0;
      data_in   = 8'h17;
      wait_valid("pending_id5", ok);
      base = got_q.size();
      data_in = 8'h1F;
      for (int k = 0; k < 8; k++) tick();
      data_in = 8'h27;
      for (int k = 0; k < 8; k++) tick();
      n_checks++;
      if (tgt_valid !== 1'b1 || tgt_id !== 5'd5 || cur_target !== 5'd5) begin
         n_fail++;
         $display("FAIL pending_hold_stable got v=%0b id=%0d cur=%0d exp 1 5 5",
                  tgt_valid, tgt_id, cur_target);
      end
      tgt_ready = 1'b1;
      for (int k = 0; k < 20; k++) tick();
      n_checks++;
      if (got_q.size() - base != 2 || got_q[base] != 5 || got_q[base + 1] != 9) begin
         n_fail++;
         $display("FAIL pending_order got %0d handshakes first=%0d second=%0d exp 2: 5 then 9",
                  got_q.size() - base,
                  (got_q.size() > base) ? got_q[base] : -1,
                  (got_q.size() > base + 1) ? got_q[base + 1] : -1);
      end
      n_checks++;
      if (cur_target !== 5'd9) begin
         n_fail++;
         $display("FAIL pending_cur got=%0d exp=9", cur_target);
      end
   endtask

   task automatic test_random();
      int base, eb, dur, r, nseg;
      tgt_ready = 1'b1;
      data_in   = 8'h00;
      do_reset();
      m_last = 0; m_run = 1; m_cur = 0; m_act = 0; m_cnt = 0; m_err = 0;
      exp_q.delete();
      base = got_q.size();
      eb   = err_seen;
      model_on = 1;
      nseg = 120;
      for (int s = 0; s < nseg; s++) begin
         r = $urandom_range(0, 9);
         if (r < 5)       data_in = {1'b0, 5'($urandom_range(0, 22)), 2'b11};
         else if (r == 5) data_in = 8'h03;
         else if (r == 6) data_in = {1'b1, 5'($urandom_range(0, 31)), 2'b11};
         else             data_in = 8'($urandom_range(0, 255));
         dur = $urandom_range(1, 10);
         for (int k = 0; k < dur; k++) tick();
      end
      for (int k = 0; k < 20; k++) tick();
      model_on = 0;
      n_checks++;
      if (got_q.size() - base != exp_q.size()) begin
         n_fail++;
         $display("FAIL random_handshake_count got=%0d exp=%0d", got_q.size() - base, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
         n_checks++;
         if (got_q[base + i] != exp_q[i]) begin
            n_fail++;
            $display("FAIL random_id[%0d] got=%0d exp=%0d", i, got_q[base + i], exp_q[i]);
         end
      end
      n_checks++;
      if (err_seen - eb != m_err) begin
         n_fail++;
         $display("FAIL random_err_count got=%0d exp=%0d", err_seen - eb, m_err);
      end
      n_checks++;
      if (int'(cur_target) != m_cur || int'(target_active) != m_act || int'(frame_cnt) != m_cnt) begin
         n_fail++;
         $display("FAIL random_final got cur=%0d act=%0b cnt=%0d exp %0d %0d %0d",
                  cur_target, target_active, frame_cnt, m_cur, m_act, m_cnt);
      end
   endtask

   task automatic test_saturate();
      bit ok;
      int exp_cnt, vcount;
      tgt_ready = 1'b1;
      data_in   = 8'h00;
      do_reset();
      exp_cnt = 0;
      for (int i = 0; i < 260; i++) begin
         data_in = {1'b0, 5'((i % 20) + 1), 2'b11};
         wait_valid("saturate", ok);
         if (!ok) break;
         tick();
         if (exp_cnt < 255) exp_cnt++;
         n_checks++;
         if (int'(frame_cnt) != exp_cnt) begin
            n_fail++;
            $display("FAIL saturate_cnt[%0d] got=%0d exp=%0d", i, frame_cnt, exp_cnt);
         end
      end
      // reset while holding, with another frame parked in pending
      tgt_ready = 1'b0;
      data_in   = 8'h17;
      wait_valid("rst_hold", ok);
      data_in = 8'h1F;
      for (int k = 0; k < 8; k++) tick();
      rst = 1'b1;
      tick();
      n_checks++;
      if ({tgt_valid, tgt_id, cur_target, target_active, err_frame, frame_cnt} !== '0) begin
         n_fail++;
         $display("FAIL rst_hold_outputs got v=%0b id=%0d cur=%0d act=%0b err=%0b cnt=%0d exp all 0",
                  tgt_valid, tgt_id, cur_target, target_active, err_frame, frame_cnt);
      end
      rst       = 1'b0;
      data_in   = 8'h00;
      tgt_ready = 1'b1;
      vcount    = 0;
      for (int k = 0; k < 15; k++) begin
         tick();
         if (tgt_valid === 1'b1) vcount++;
      end
      n_checks++;
      if (vcount != 0 || frame_cnt !== 8'd0) begin
         n_fail++;
         $display("FAIL rst_pending_discard got v=%0d cnt=%0d exp 0 0", vcount, frame_cnt);
      end
   endtask

   initial begin
      rst       = 1'b1;
      data_in   = 8'h00;
      tgt_ready = 1'b0;
      test_reset();
      test_latency();
      test_debounce();
      test_range();
      test_channel();
      test_pending();
      test_random();
      test_saturate();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
